s27_trojan_screen_ctrl: RTL and testbench

- Test-sequencing controller for the s27 benchmark flow.
- Drives the four primary inputs (G0..G3) shared by a suspect s27 instance (DUT) and a golden s27 instance (REF).
- Flushes their state flops, then applies an LFSR pattern stream and compares G17_DUT against G17_REF every cycle.
- Reports mismatch count, first failing vector index and pass/fail; this is the on-chip trojan screen for the s27 benchmark variants.

---
 rtl/s27_trojan_screen_ctrl.sv | 107 ++++++++++
 tb/tb_s27_trojan_screen_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/s27_trojan_screen_ctrl.sv
// Trojan screen sequencer for s27: flushes both instances, streams LFSR vectors,
// and compares suspect vs golden G17 on every RUN cycle.
module s27_trojan_screen_ctrl #(
    parameter int         NUM_VECTORS = 256,
    parameter int         WARMUP      = 2,
    parameter logic [3:0] FLUSH_VEC   = 4'h3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         CNT_W       = 16
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             G17_DUT,
    input  logic             G17_REF,
    output logic             G0,
    output logic             G1,
    output logic             G2,
    output logic             G3,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [CNT_W-1:0] MISMATCH_CNT,
    output logic [15:0]      FIRST_FAIL_IDX,
    output logic [15:0]      VEC_IDX
);

    // An all-zero seed would lock the LFSR, so it is nudged to 1.
    localparam logic [7:0]  SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LAST_WARM = 16'(WARMUP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [15:0] warm_cnt;
    logic [3:0]  g;
    logic        mismatch;
    logic [7:0]  lfsr_nxt;

    assign {G3, G2, G1, G0} = g;
    assign mismatch = G17_DUT ^ G17_REF;
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state          <= S_IDLE;
            g              <= 4'h0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            FAIL           <= 1'b0;
            MISMATCH_CNT   <= '0;
            FIRST_FAIL_IDX <= 16'hFFFF;
            VEC_IDX        <= 16'd0;
            lfsr           <= SEED;
            warm_cnt       <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state          <= S_WARM;
                        g              <= FLUSH_VEC;
                        BUSY           <= 1'b1;
                        DONE           <= 1'b0;
                        FAIL           <= 1'b0;
                        MISMATCH_CNT   <= '0;
                        FIRST_FAIL_IDX <= 16'hFFFF;
                        VEC_IDX        <= 16'd0;
                        lfsr           <= SEED;
                        warm_cnt       <= 16'd0;
                    end
                end
                S_WARM: begin
                    if (warm_cnt == LAST_WARM) begin
                        state   <= S_RUN;
                        g       <= lfsr[3:0];
                        VEC_IDX <= 16'd0;
                    end else begin
                        warm_cnt <= warm_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    // Compare is against the vector applied during the cycle now closing.
                    if (mismatch) begin
                        FAIL <= 1'b1;
                        if (MISMATCH_CNT != '1)
                            MISMATCH_CNT <= MISMATCH_CNT + CNT_W'(1);
                        if (FIRST_FAIL_IDX == 16'hFFFF)
                            FIRST_FAIL_IDX <= VEC_IDX;
                    end
                    lfsr    <= lfsr_nxt;
                    VEC_IDX <= VEC_IDX + 16'd1;
                    if (VEC_IDX == LAST_VEC) begin
                        state <= S_DONE;
                        g     <= 4'h0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        g <= lfsr_nxt[3:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s27_trojan_screen_ctrl.sv
// Randomized bench for s27_trojan_screen_ctrl: two parameterizations checked each
// cycle against a timeline model (edges since START), plus literal pin checks.
module tb_s27_trojan_screen_ctrl;

    localparam int W0 = 2, NV0 = 256;
    localparam int W1 = 3, NV1 = 20;

    logic             CK = 1'b0;
    logic             RSTN;
    logic [1:0]       start, g17d, g17r, gb0, gb1, gb2, gb3, busy, done, fail;
    logic [15:0]      cnt0;
    logic [3:0]       cnt1;
    logic [1:0][15:0] ffi, vec;

    always #5 CK = ~CK;

    s27_trojan_screen_ctrl u_dut0 (
        .CK(CK), .RSTN(RSTN), .START(start[0]), .G17_DUT(g17d[0]), .G17_REF(g17r[0]),
        .G0(gb0[0]), .G1(gb1[0]), .G2(gb2[0]), .G3(gb3[0]),
        .BUSY(busy[0]), .DONE(done[0]), .FAIL(fail[0]),
        .MISMATCH_CNT(cnt0), .FIRST_FAIL_IDX(ffi[0]), .VEC_IDX(vec[0])
    );

    s27_trojan_screen_ctrl #(.NUM_VECTORS(NV1), .WARMUP(W1), .LFSR_SEED(8'h00), .CNT_W(4)) u_dut1 (
        .CK(CK), .RSTN(RSTN), .START(start[1]), .G17_DUT(g17d[1]), .G17_REF(g17r[1]),
        .G0(gb0[1]), .G1(gb1[1]), .G2(gb2[1]), .G3(gb3[1]),
        .BUSY(busy[1]), .DONE(done[1]), .FAIL(fail[1]),
        .MISMATCH_CNT(cnt1), .FIRST_FAIL_IDX(ffi[1]), .VEC_IDX(vec[1])
    );

    int checks = 0, errors = 0;
    int wp[2]   = '{W0, W1};
    int nvp[2]  = '{NV0, NV1};
    int cmax[2] = '{65535, 15};
    logic [7:0] seqv[2][256];

    // Model: n = edges since START accepted (-1 idle), plus result registers.
    int n[2], cnt_m[2], ffi_m[2];
    bit fail_m[2];
    bit model_ok = 0;
    bit st[2];
    int mode[2];
    bit rst_v;
    bit mm[2];

    function automatic logic [7:0] lfsr_step(logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int g_of(int i);
        return int'({gb3[i], gb2[i], gb1[i], gb0[i]});
    endfunction

    function automatic int cnt_of(int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(string nm, int inst, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            int eg, eb, ed, ev;
            if (n[i] < 0) begin
                eg = 0; eb = 0; ed = 0; ev = 0;
            end else if (n[i] <= wp[i]) begin
                eg = 3; eb = 1; ed = 0; ev = 0;
            end else if (n[i] <= wp[i] + nvp[i]) begin
                ev = n[i] - wp[i] - 1;
                eg = int'(seqv[i][ev][3:0]); eb = 1; ed = 0;
            end else begin
                eg = 0; eb = 0; ed = 1; ev = nvp[i];
            end
            chk("G", i, g_of(i), eg);
            chk("BUSY", i, int'(busy[i]), eb);
            chk("DONE", i, int'(done[i]), ed);
            chk("VEC_IDX", i, int'(vec[i]), ev);
            chk("FAIL_FLAG", i, int'(fail[i]), int'(fail_m[i]));
            chk("MISMATCH_CNT", i, cnt_of(i), cnt_m[i]);
            chk("FIRST_FAIL_IDX", i, int'(ffi[i]), ffi_m[i]);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!RSTN) begin
                n[i] = -1; cnt_m[i] = 0; ffi_m[i] = 65535; fail_m[i] = 0;
            end else if (n[i] < 0 || n[i] > wp[i] + nvp[i]) begin
                if (start[i]) begin
                    n[i] = 1; cnt_m[i] = 0; ffi_m[i] = 65535; fail_m[i] = 0;
                end
            end else begin
                if (n[i] > wp[i] && mm[i]) begin
                    fail_m[i] = 1;
                    if (cnt_m[i] < cmax[i]) cnt_m[i]++;
                    if (ffi_m[i] == 65535) ffi_m[i] = n[i] - wp[i] - 1;
                end
                n[i]++;
            end
        end
        model_ok = 1;
    endtask

    task automatic cycle();
        @(negedge CK);
        if (model_ok) compare();
        RSTN = rst_v;
        for (int i = 0; i < 2; i++) begin
            logic r;
            bit inrun, inwarm;
            r      = 1'($urandom_range(0, 1));
            inwarm = n[i] >= 1 && n[i] <= wp[i];
            inrun  = n[i] > wp[i] && n[i] <= wp[i] + nvp[i];
            case (mode[i])
                1:       mm[i] = inwarm || (inrun && (n[i] - wp[i] - 1) == 5);
                2:       mm[i] = 1;
                3:       mm[i] = ($urandom_range(0, 3) == 0);
                default: mm[i] = 0;
            endcase
            start[i] = st[i];
            g17r[i]  = r;
            g17d[i]  = r ^ mm[i];
        end
        @(posedge CK);
        model_update();
    endtask

    task automatic run(int c);
        for (int k = 0; k < c; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] s;
            s = (i == 0) ? 8'hA5 : 8'h01;
            for (int k = 0; k < 256; k++) begin
                seqv[i][k] = s;
                s = lfsr_step(s);
            end
            n[i] = -1; cnt_m[i] = 0; ffi_m[i] = 65535; fail_m[i] = 0;
            st[i] = 0; mode[i] = 0;
        end
        RSTN = 1'b0; start = '0; g17d = '0; g17r = '0; rst_v = 0;

        // Reset held two cycles.
        run(2); #2;
        chk("rst_G", 0, g_of(0), 0);
        chk("rst_FFI", 0, int'(ffi[0]), 16'hFFFF);
        chk("rst_BUSY", 1, int'(busy[1]), 0);
        rst_v = 1;

        // Clean run on inst0; permanent mismatch (saturation) on inst1.
        mode[1] = 2; st[0] = 1; st[1] = 1; cycle(); st[0] = 0; st[1] = 0;
        run(2); #2;
        chk("first_nibble", 0, g_of(0), 5);
        cycle(); #2;
        chk("second_nibble", 0, g_of(0), 4'hA);
        chk("seed0_nibble", 1, g_of(1), 1);
        cycle(); #2;
        chk("third_nibble", 0, g_of(0), 5);
        for (int e = 6; e <= 258; e++) begin
            st[0] = ($urandom_range(0, 7) == 0);
            cycle();
        end
        st[0] = 0; #2;
        chk("done_early", 0, int'(done[0]), 0);
        cycle(); #2;
        chk("done_at_259", 0, int'(done[0]), 1);
        chk("clean_fail", 0, int'(fail[0]), 0);
        chk("clean_cnt", 0, int'(cnt0), 0);
        chk("clean_ffi", 0, int'(ffi[0]), 16'hFFFF);
        chk("clean_vec", 0, int'(vec[0]), 256);
        chk("sat_cnt", 1, int'(cnt1), 15);
        chk("sat_ffi", 1, int'(ffi[1]), 0);
        chk("sat_vec", 1, int'(vec[1]), 20);

        // Restart from DONE with a single mismatch at vector 5 (plus warm noise).
        mode[0] = 1; mode[1] = 3; st[0] = 1; st[1] = 1; cycle(); st[0] = 0; st[1] = 0;
        run(259); #2;
        chk("inj_done", 0, int'(done[0]), 1);
        chk("inj_fail", 0, int'(fail[0]), 1);
        chk("inj_cnt", 0, int'(cnt0), 1);
        chk("inj_ffi", 0, int'(ffi[0]), 5);

        // Reset in the middle of a random run, then rerun.
        mode[0] = 3; st[0] = 1; st[1] = 1; cycle(); st[0] = 0; st[1] = 0;
        for (int c = 0; c < 400 && n[0] != W0 + 1 + 100; c++) cycle();
        #2;
        chk("mid_vec", 0, int'(vec[0]), 100);
        rst_v = 0; cycle(); #2;
        chk("midrst_vec", 0, int'(vec[0]), 0);
        chk("midrst_busy", 0, int'(busy[0]), 0);
        chk("midrst_ffi", 0, int'(ffi[0]), 16'hFFFF);
        chk("midrst_G", 0, g_of(0), 0);
        rst_v = 1; run(1);
        st[0] = 1; st[1] = 1; cycle(); st[0] = 0; st[1] = 0;
        run(259); #2;
        chk("rerun_done", 0, int'(done[0]), 1);
        chk("rerun_vec", 0, int'(vec[0]), 256);
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
